// File: rtl/serial_image_loader_pkg.sv
// Shared constants for the serial image loader.
// Holds the framing bytes, the error codes reported on errCode, the FSM state
// encoding, and a small helper used to size shared buffers.
package serial_image_loader_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam logic [7:0] CMD_IMAGE   = 8'h01;
  localparam logic [7:0] CMD_OPCODES = 8'h02;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CMD     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/serial_image_loader_frame_timeout_counter.sv
// Inter-byte idle timer for a framed serial link.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   clear     - restart the idle count (a byte arrived, or no frame is open)
//   enable    - count idle cycles while a frame is open
//   expired   - high during the TimeoutCycles-th consecutive idle cycle
// A clear in the same cycle as the would-be expiry suppresses it, so a late
// byte always wins over the timeout.
module frame_timeout_counter #(
  parameter int TimeoutCycles = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TimeoutCycles + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  assign expired = enable && !clear && (cnt == CW'(TimeoutCycles - 1));

endmodule

// File: rtl/serial_image_loader.sv
// Serial image/program loader for the morphologic processor.
// Frames: SYNC(0xA5) CMD payload CHK, CHK = XOR of CMD and payload.
// CMD 0x01 loads the image, CMD 0x02 loads the opcode program. Payload is
// collected in a shadow register and committed only on a matching checksum.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   rxData, rxValid   - received byte stream, one strobe per byte
//   image             - committed image, row 0 in the MSBs
//   opcodes           - committed program, first opcode in the MSBs
//   start             - one-cycle pulse after an image commit
//   busy              - a frame is in progress
//   errCode/errStrobe - last error and a pulse when a nonzero code is written
module serial_image_loader
  import serial_image_loader_pkg::*;
#(
  parameter int ImageWidth    = 8,
  parameter int ImageHeight   = 4,
  parameter int OpCount       = 2,
  parameter int TimeoutCycles = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rxData,
  input  logic                              rxValid,
  output logic [ImageWidth*ImageHeight-1:0] image,
  output logic [16*OpCount-1:0]             opcodes,
  output logic                              start,
  output logic                              busy,
  output logic [1:0]                        errCode,
  output logic                              errStrobe
);

  localparam int IMG_W = ImageWidth * ImageHeight;
  localparam int OP_W  = 16 * OpCount;
  localparam int IB    = IMG_W / 8;
  localparam int OB    = OP_W / 8;
  // One shadow serves both commands; payloads are byte-exact so the low
  // IMG_W / OP_W bits hold the full frame after the last payload byte.
  localparam int SH_W  = max_int(IMG_W, OP_W);
  localparam int CNT_W = $clog2(max_int(IB, OB) + 1);

  logic [1:0]       state;
  logic             is_img;
  logic [CNT_W-1:0] byte_cnt;
  logic [7:0]       xsum;
  logic [SH_W-1:0]  shadow;
  logic             expired;

  frame_timeout_counter #(
    .TimeoutCycles(TimeoutCycles)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (rxValid || (state == ST_IDLE)),
    .enable (state != ST_IDLE),
    .expired(expired)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      is_img    <= 1'b0;
      byte_cnt  <= '0;
      xsum      <= '0;
      shadow    <= '0;
      image     <= '0;
      opcodes   <= '0;
      start     <= 1'b0;
      errCode   <= ERR_NONE;
      errStrobe <= 1'b0;
    end else begin
      start     <= 1'b0;
      errStrobe <= 1'b0;
      // expired is already masked by rxValid, so a byte on the expiry cycle
      // is processed normally.
      if (expired) begin
        state     <= ST_IDLE;
        shadow    <= '0;
        errCode   <= ERR_TIMEOUT;
        errStrobe <= 1'b1;
      end else if (rxValid) begin
        case (state)
          ST_IDLE: begin
            if (rxData == SYNC_BYTE) state <= ST_CMD;
          end
          ST_CMD: begin
            if (rxData == CMD_IMAGE || rxData == CMD_OPCODES) begin
              is_img   <= (rxData == CMD_IMAGE);
              byte_cnt <= (rxData == CMD_IMAGE) ? CNT_W'(IB) : CNT_W'(OB);
              xsum     <= rxData;
              shadow   <= '0;
              state    <= ST_PAYLOAD;
            end else begin
              errCode   <= ERR_CMD;
              errStrobe <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            shadow   <= {shadow[SH_W-9:0], rxData};
            xsum     <= xsum ^ rxData;
            byte_cnt <= byte_cnt - CNT_W'(1);
            if (byte_cnt == CNT_W'(1)) state <= ST_CHECK;
          end
          ST_CHECK: begin
            if (rxData == xsum) begin
              if (is_img) begin
                image <= shadow[IMG_W-1:0];
                start <= 1'b1;
              end else begin
                opcodes <= shadow[OP_W-1:0];
              end
              errCode <= ERR_NONE;
            end else begin
              errCode   <= ERR_CHK;
              errStrobe <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
